arith_shift_sequencer: RTL and testbench

//   Multi-bit arithmetic shift sequencer wrapped around the 4-bit one-position arithmetic shift stage.
//   - Accepts an operand pair, a 2-bit select and a shift count through a valid/ready handshake.
//   - Feeds its working register to the stage once per cycle, for count cycles.
//   - Writes the stage result back into the working register each cycle.
//   - Presents the final result downstream through a valid/ready handshake.
//

---
 rtl/arith_shift_sequencer.sv | 126 ++++++++++++
 tb/tb_arith_shift_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_shift_sequencer.sv
// Multi-bit arithmetic shifter that drives an external 1-position shift stage once per cycle; accept->out_valid takes count+1 cycles.
// Holds the result until out_ready; the sticky left-shift ovf flag is built only when ALSU_SHIFT_OVF_EN is defined.
module arith_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Sel,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] stage_a,
  output logic [WIDTH-1:0] stage_b,
  output logic [1:0]       stage_sel,
  input  logic [WIDTH-1:0] stage_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sel_d      = Sel;
          work_d     = Sel[1] ? B : A;
          cnt_d      = count;
          in_ready_d = 1'b0;
          if (count == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Stage is combinational: its output for this cycle's work is written back now.
        work_d = stage_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALSU_SHIFT_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid)
      ovf_d = 1'b0;
    else if (state_q == SHIFT && sel_q[0])
      ovf_d = ovf_q | (work_q[WIDTH-1] ^ stage_out[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = work_q;
  assign stage_a   = work_q;
  assign stage_b   = work_q;
  assign stage_sel = sel_q;

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Bench for arith_shift_sequencer: models the 1-position shift stage and checks results against an arithmetic reference.
module tb_arith_shift_sequencer;
  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [W-1:0]  A, B, stage_a, stage_b, stage_out, result;
  logic [1:0]    Sel, stage_sel;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arith_shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .count(count),
    .stage_a(stage_a), .stage_b(stage_b), .stage_sel(stage_sel), .stage_out(stage_out),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  // The one-position shift stage the sequencer wraps.
  logic [W-1:0] stage_op;
  always_comb begin
    stage_op  = stage_sel[1] ? stage_b : stage_a;
    stage_out = stage_sel[0] ? {stage_op[W-2:0], 1'b0} : {stage_op[W-1], stage_op[W-1:1]};
  end

  // Reference: {ovf, result} from plain arithmetic on the selected operand.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] s, input logic [CW-1:0] c);
    logic [W-1:0] op;
    logic signed [W-1:0] sv;
    int v, nxt;
    logic ov;
    logic [W-1:0] res;
    op = s[1] ? b : a;
    ov = 1'b0;
    if (!s[0]) begin
      sv  = op;
      res = sv >>> c;
    end else begin
      v = int'(op);
      for (int i = 0; i < int'(c); i++) begin
        nxt = (v * 2) % 16;
        if ((v >= 8) != (nxt >= 8)) ov = 1'b1;
        v = nxt;
      end
      res = v[W-1:0];
    end
`ifndef ALSU_SHIFT_OVF_EN
    ov = 1'b0;
`endif
    return {ov, res};
  endfunction

  // Drives one op from a negedge; returns the result, ovf and accept->valid latency; ends on a negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                        input logic [CW-1:0] c, output logic [W-1:0] res, output logic ov,
                        output int lat);
    int guard;
    A = a; B = b; Sel = s; count = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Sel = 2'($urandom); count = CW'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    ov  = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Sel = 2'b00; count = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, ovf, stage_sel} !== {1'b1, 1'b0, 4'b0000, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%b ovf=%b sel=%b required rdy=1 vld=0 res=0000 ovf=0 sel=00",
               in_ready, out_valid, result, ovf, stage_sel);
    end
    A = 4'b1000; Sel = 2'b00; count = 3'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, ovf} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_shift got rdy=%b vld=%b res=%b ovf=%b required rdy=1 vld=0 res=0000 ovf=0",
               in_ready, out_valid, result, ovf);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort out_valid=%b required=0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] r;
    logic o;
    int lat;
    run_op(4'b1000, 4'b0000, 2'b00, 3'd3, r, o, lat);
    checks++;
    if (r !== 4'b1111 || lat != 4) begin
      failures++;
      $display("FAIL right_neg got res=%b lat=%0d required res=1111 lat=4", r, lat);
    end
    run_op(4'b0000, 4'b0011, 2'b11, 3'd2, r, o, lat);
    checks++;
    if ({o, r} !== ref_op(4'b0000, 4'b0011, 2'b11, 3'd2) || r !== 4'b1100 || lat != 3) begin
      failures++;
      $display("FAIL left_b got ovf=%b res=%b lat=%0d required ovf/res=%b res=1100 lat=3",
               o, r, lat, ref_op(4'b0000, 4'b0011, 2'b11, 3'd2));
    end
    run_op(4'b0101, 4'b1111, 2'b01, 3'd0, r, o, lat);
    checks++;
    if (r !== 4'b0101 || o !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL count_zero got res=%b ovf=%b lat=%0d required res=0101 ovf=0 lat=1", r, o, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp1, exp2;
    logic [W-1:0] held;
    int guard;
    exp1 = ref_op(4'b0110, 4'b0000, 2'b01, 3'd2);
    exp2 = ref_op(4'b1010, 4'b0000, 2'b00, 3'd1);
    A = 4'b0110; B = 4'b0000; Sel = 2'b01; count = 3'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    held = result;
    checks++;
    if ({ovf, result} !== exp1) begin
      failures++;
      $display("FAIL bp_result got ovf/res=%b required=%b", {ovf, result}, exp1);
    end
    A = 4'b1010; B = 4'b0000; Sel = 2'b00; count = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0 || ovf !== exp1[W]) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got vld=%b res=%b rdy=%b ovf=%b required vld=1 res=%b rdy=0 ovf=%b",
                 i, out_valid, result, in_ready, ovf, held, exp1[W]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_held_accept in_ready=%b required=0", in_ready);
    end
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if ({ovf, result} !== exp2 || result !== 4'b1101) begin
      failures++;
      $display("FAIL bp_second got ovf/res=%b required=%b", {ovf, result}, exp2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r;
    logic o;
    int lat;
    run_op(4'b0000, 4'b0110, 2'b10, 3'd7, r, o, lat);
    checks++;
    if (r !== 4'b0000 || o !== 1'b0 || lat != 8) begin
      failures++;
      $display("FAIL b2b_first got res=%b ovf=%b lat=%0d required res=0000 ovf=0 lat=8", r, o, lat);
    end
    run_op(4'b1001, 4'b0000, 2'b01, 3'd1, r, o, lat);
    checks++;
    if ({o, r} !== ref_op(4'b1001, 4'b0000, 2'b01, 3'd1) || r !== 4'b0010 || lat != 2) begin
      failures++;
      $display("FAIL b2b_second got ovf=%b res=%b lat=%0d required ovf/res=%b lat=2",
               o, r, lat, ref_op(4'b1001, 4'b0000, 2'b01, 3'd1));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r;
    logic [1:0] s;
    logic [CW-1:0] c;
    logic o;
    logic [W:0] exp;
    int lat;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom); b = W'($urandom); s = 2'($urandom); c = CW'($urandom);
      exp = ref_op(a, b, s, c);
      run_op(a, b, s, c, r, o, lat);
      checks++;
      if ({o, r} !== exp || lat != int'(c) + 1 || stage_sel !== s) begin
        failures++;
        $display("FAIL random n=%0d a=%b b=%b sel=%b cnt=%0d got ovf/res=%b lat=%0d ssel=%b required %b lat=%0d ssel=%b",
                 n, a, b, s, c, {o, r}, lat, stage_sel, exp, int'(c) + 1, s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
